run_dump_ctrl: RTL and testbench

RUN_DUMP_CTRL -- requirements
Module: run_dump_ctrl

---
 rtl/run_dump_pkg.sv | 15 +
 rtl/run_dump_ctrl.sv | 148 ++++++++++++++
 tb/tb_run_dump_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_dump_pkg.sv
// Shared definitions for the run/dump controller: controller states and
// the width of the completed-run-cycle counter.
package run_dump_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/run_dump_ctrl.sv
// Run/dump controller: holds the CPU under test in reset, lets it run for a
// fixed number of cycles, freezes it and streams its register file out.
// Optional feature: define RUN_DUMP_HALT_EN to add halt_i, which ends the
// run phase early.
//
// Dump stream handshake: a beat transfers on a rising edge where
// dump_valid_o=1 and dump_ready_i=1. While dump_valid_o=1 and dump_ready_i=0,
// dump_idx_o and dump_data_o hold. dump_valid_o never depends
// combinationally on dump_ready_i.
module run_dump_ctrl
  import run_dump_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_N     = 32,
  parameter int IDX_W     = 5,
  parameter int HOLD_CYC  = 1,
  parameter int END_COUNT = 100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
`ifdef RUN_DUMP_HALT_EN
  input  logic              halt_i,
`endif
  output logic              cpu_rst_o,
  output logic              cpu_en_o,
  output logic [IDX_W-1:0]  rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              done_o,
  output logic [2:0]        state_o
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(REG_N - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(END_COUNT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e              state_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [CNT_W-1:0]    cycle_cnt_q;
  logic                valid_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    addr_q;

  logic halt_w;
  logic start_ok;
  logic hold_done;
  logic run_last;
  logic accept;
  logic last_idx;
  logic load;

`ifdef RUN_DUMP_HALT_EN
  assign halt_w = halt_i;
`else
  assign halt_w = 1'b0;
`endif

  // start_i only matters while idle or finished; it is ignored mid-run.
  assign start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign hold_done = (hold_cnt_q == HOLD_LAST);
  assign run_last  = (cycle_cnt_q == RUN_LAST) || halt_w;
  assign accept    = valid_q && dump_ready_i;
  assign last_idx  = (idx_q == LAST_IDX);
  // Fill the output register on DUMP entry and on every non-final accept.
  assign load      = (state_q == ST_DUMP) && (!valid_q || (accept && !last_idx));

  // Phase sequencing IDLE -> HOLD -> RUN -> DUMP -> DONE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_q <= ST_HOLD;
        ST_HOLD: if (hold_done) state_q <= ST_RUN;
        ST_RUN:  if (run_last) state_q <= ST_DUMP;
        ST_DUMP: if (accept && last_idx) state_q <= ST_DONE;
        ST_DONE: if (start_i) state_q <= ST_HOLD;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Count cycles spent in HOLD; zero whenever not holding.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hold_cnt_q <= '0;
    end else if (state_q == ST_HOLD) begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
    end else begin
      hold_cnt_q <= '0;
    end
  end

  // Completed RUN cycles, saturating; cleared on an accepted start.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= '0;
    end else if (start_ok) begin
      cycle_cnt_q <= '0;
    end else if ((state_q == ST_RUN) && (cycle_cnt_q != CNT_MAX)) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
    end
  end

  // Dump output register and register-file read pointer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else if (start_ok) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      idx_q   <= addr_q;
      data_q  <= rf_data_i;
      // The pointer parks on the last register once it has been addressed.
      if (addr_q != LAST_IDX) begin
        addr_q <= addr_q + IDX_W'(1);
      end
    end else if (accept && last_idx) begin
      valid_q <= 1'b0;
    end
  end

  assign cpu_rst_o    = (state_q == ST_RUN) || (state_q == ST_DUMP) || (state_q == ST_DONE);
  assign cpu_en_o     = (state_q == ST_RUN);
  assign rf_addr_o    = addr_q;
  assign dump_valid_o = valid_q;
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = data_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign done_o       = (state_q == ST_DONE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Bench for run_dump_ctrl: a timeline model (cycles since start) predicts
// every output each cycle, a queue holds the register values expected to be
// dumped, and directed scenarios pin the model with literal counts.
module tb_run_dump_ctrl;
  import run_dump_pkg::*;

  localparam int DATA_W    = 32;
  localparam int REG_N     = 32;
  localparam int IDX_W     = 5;
  localparam int HOLD_CYC  = 1;
  localparam int END_COUNT = 100;
  localparam int BOUND     = 3000;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_i;
  logic              start_i;
  logic              dump_ready_i;
  logic              cpu_rst_o, cpu_en_o, dump_valid_o, done_o;
  logic [IDX_W-1:0]  rf_addr_o, dump_idx_o;
  logic [DATA_W-1:0] rf_data_i, dump_data_o;
  logic [CNT_W-1:0]  cycle_cnt_o;
  logic [2:0]        state_o;
  logic [DATA_W-1:0] rf_mem [0:REG_N-1];
`ifdef RUN_DUMP_HALT_EN
  logic halt_i;
  wire  halt_seen = halt_i;
`else
  wire  halt_seen = 1'b0;
`endif

  assign rf_data_i = rf_mem[rf_addr_o];

  run_dump_ctrl #(
    .DATA_W(DATA_W), .REG_N(REG_N), .IDX_W(IDX_W),
    .HOLD_CYC(HOLD_CYC), .END_COUNT(END_COUNT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
`ifdef RUN_DUMP_HALT_EN
    .halt_i(halt_i),
`endif
    .cpu_rst_o(cpu_rst_o), .cpu_en_o(cpu_en_o), .rf_addr_o(rf_addr_o),
    .rf_data_i(rf_data_i), .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o), .cycle_cnt_o(cycle_cnt_o),
    .done_o(done_o), .state_o(state_o)
  );

  // Small corner-case instance: 3 hold cycles, 1 run cycle, 2 registers.
  logic              s_start, s_ready;
  logic              s_cpu_rst, s_cpu_en, s_valid, s_done;
  logic [0:0]        s_addr, s_idx;
  logic [DATA_W-1:0] s_rdata, s_data;
  logic [CNT_W-1:0]  s_cnt;
  logic [2:0]        s_state;
  logic [DATA_W-1:0] s_rf [0:1];
  assign s_rdata = s_rf[s_addr];

  run_dump_ctrl #(
    .DATA_W(DATA_W), .REG_N(2), .IDX_W(1), .HOLD_CYC(3), .END_COUNT(1)
  ) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(s_start),
`ifdef RUN_DUMP_HALT_EN
    .halt_i(1'b0),
`endif
    .cpu_rst_o(s_cpu_rst), .cpu_en_o(s_cpu_en), .rf_addr_o(s_addr),
    .rf_data_i(s_rdata), .dump_valid_o(s_valid), .dump_ready_i(s_ready),
    .dump_idx_o(s_idx), .dump_data_o(s_data), .cycle_cnt_o(s_cnt),
    .done_o(s_done), .state_o(s_state)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t counts edges since the accepted start. Hold covers m_t < HOLD_CYC,
  // run covers the next m_run_len cycles, the next cycle is dump entry and
  // beats are offered from the one after that until REG_N are taken.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_t      = 0;
  int m_run_len = END_COUNT;
  int m_beats  = 0;
  logic [DATA_W-1:0] exp_q[$];

  function automatic bit model_running();
    return m_active && !m_done && (m_t >= HOLD_CYC) && (m_t < HOLD_CYC + m_run_len);
  endfunction

  function automatic bit model_valid();
    return m_active && !m_done && (m_t >= HOLD_CYC + m_run_len + 1);
  endfunction

  function automatic int model_cnt();
    if (!m_active || m_t < HOLD_CYC) return 0;
    if (m_t - HOLD_CYC > m_run_len) return m_run_len;
    return m_t - HOLD_CYC;
  endfunction

  function automatic int next_len();
    if (model_running() && halt_seen) return m_t - HOLD_CYC + 1;
    return m_run_len;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_active  <= 1'b0;
      m_done    <= 1'b0;
      m_t       <= 0;
      m_run_len <= END_COUNT;
      m_beats   <= 0;
      exp_q.delete();
    end else if (!m_active || m_done) begin
      if (start_i) begin
        m_active  <= 1'b1;
        m_done    <= 1'b0;
        m_t       <= 0;
        m_run_len <= END_COUNT;
        m_beats   <= 0;
        exp_q.delete();
      end
    end else begin
      if (model_valid() && dump_ready_i) begin
        void'(exp_q.pop_front());
        m_beats <= m_beats + 1;
        if (m_beats + 1 == REG_N) m_done <= 1'b1;
      end
      if (m_t + 1 == HOLD_CYC + next_len()) begin
        for (int i = 0; i < REG_N; i++) exp_q.push_back(rf_mem[i]);
      end
      m_run_len <= next_len();
      m_t       <= m_t + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  int idx5_cycles = 0;

  always @(negedge clk_i) begin
    chk("cpu_rst", cpu_rst_o, m_active && (m_t >= HOLD_CYC));
    chk("cpu_en", cpu_en_o, model_running());
    chk("done", done_o, m_done);
    chk("cycle_cnt", cycle_cnt_o, model_cnt());
    chk("dump_valid", dump_valid_o, model_valid());
    if (model_valid()) begin
      chk("dump_idx", dump_idx_o, m_beats);
      if (exp_q.size() != 0) begin
        chk("dump_data", dump_data_o, exp_q[0]);
      end else begin
        tests++;
        fails++;
        $display("FAIL dump_queue: got empty expected %0d entries", REG_N - m_beats);
      end
    end
    if (m_active && !m_done && (m_t == HOLD_CYC + m_run_len)) chk("rf_addr_entry", rf_addr_o, 0);
    if (!rst_i) begin
      chk("rst_idx", dump_idx_o, 0);
      chk("rst_data", dump_data_o, 0);
      chk("rst_addr", rf_addr_o, 0);
    end
    if (dump_valid_o && dump_idx_o == 5) idx5_cycles++;
  end

  // ---------------- driver: ready pattern and CPU activity ----------------
  int ready_mode = 0;
  int stall_n    = 0;

  initial begin
    dump_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0: dump_ready_i = 1'b1;
        1: dump_ready_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (dump_valid_o && dump_idx_o == 5 && stall_n < 3) begin
            dump_ready_i = 1'b0;
            stall_n++;
          end else begin
            dump_ready_i = 1'b1;
          end
        end
      endcase
      // The running CPU scribbles on its register file.
      if (model_running() && $urandom_range(0, 1) == 1)
        rf_mem[$urandom_range(0, REG_N - 1)] = $urandom;
    end
  end

  task automatic pulse_start();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  // Start a run and count phases at negedges until done_o (bounded).
  // start_at / halt_at: run-cycle number at which to pulse start_i / halt_i.
  task automatic run_and_count(input int start_at, input int halt_at,
                               output int hold_c, output int en_c, output int beats);
    bit first;
    bit fin;
    hold_c = 0; en_c = 0; beats = 0; first = 1'b1; fin = 1'b0;
    pulse_start();
    for (int n = 0; n < BOUND && !fin; n++) begin
      @(negedge clk_i);
      if (first) begin
        chk("cnt_cleared_on_start", cycle_cnt_o, 0);
        chk("done_cleared_on_start", done_o, 0);
        first = 1'b0;
      end
      start_i = 1'b0;
`ifdef RUN_DUMP_HALT_EN
      halt_i = 1'b0;
`endif
      if (!cpu_rst_o) hold_c++;
      if (cpu_en_o) begin
        en_c++;
        if (en_c == start_at) start_i = 1'b1;
`ifdef RUN_DUMP_HALT_EN
        if (en_c == halt_at) halt_i = 1'b1;
`endif
      end
      if (dump_valid_o && dump_ready_i) beats++;
      if (done_o) fin = 1'b1;
    end
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: got no done_o expected done within %0d cycles", BOUND);
    end
    if (halt_at < 0) begin end
  endtask

  // ---------------- main sequence ----------------
  int hc, ec, bc;

  initial begin
    bit found;
    int s_hold, s_en, s_beats;
    rst_i = 1'b0;
    start_i = 1'b0;
    s_start = 1'b0;
    s_ready = 1'b1;
`ifdef RUN_DUMP_HALT_EN
    halt_i = 1'b0;
`endif
    for (int i = 0; i < REG_N; i++) rf_mem[i] = $urandom;
    s_rf[0] = $urandom;
    s_rf[1] = $urandom;

    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_cpu_rst", cpu_rst_o, 0);
    chk("reset_cpu_en", cpu_en_o, 0);
    chk("reset_valid", dump_valid_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_cnt", cycle_cnt_o, 0);
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);

    // Plain run, ready always high.
    ready_mode = 0;
    run_and_count(-1, -1, hc, ec, bc);
    chk("run1_hold_cycles", hc, 1);
    chk("run1_en_cycles", ec, 100);
    chk("run1_beats", bc, 32);
    chk("run1_cnt", cycle_cnt_o, 100);
    chk("run1_done", done_o, 1);

    // Rerun from DONE, stray start in RUN, 3-cycle stall at index 5.
    ready_mode = 2;
    stall_n = 0;
    idx5_cycles = 0;
    run_and_count(50, -1, hc, ec, bc);
    chk("run2_idx5_cycles", idx5_cycles, 4);
    chk("run2_en_cycles", ec, 100);
    chk("run2_beats", bc, 32);
    chk("run2_cnt", cycle_cnt_o, 100);

    // Reset mid-dump at index 10, then a fresh run with random ready.
    ready_mode = 1;
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < BOUND && !found; n++) begin
      @(negedge clk_i);
      if (dump_valid_o && dump_idx_o == 10) found = 1'b1;
    end
    chk("run3_reached_idx10", found, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("abort_cpu_rst", cpu_rst_o, 0);
    chk("abort_cpu_en", cpu_en_o, 0);
    chk("abort_valid", dump_valid_o, 0);
    chk("abort_idx", dump_idx_o, 0);
    chk("abort_data", dump_data_o, 0);
    chk("abort_addr", rf_addr_o, 0);
    chk("abort_cnt", cycle_cnt_o, 0);
    chk("abort_done", done_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    run_and_count(-1, -1, hc, ec, bc);
    chk("run3_beats", bc, 32);
    chk("run3_cnt", cycle_cnt_o, 100);

`ifdef RUN_DUMP_HALT_EN
    // Halt during run cycle 37.
    ready_mode = 0;
    run_and_count(-1, 37, hc, ec, bc);
    chk("halt_en_cycles", ec, 37);
    chk("halt_cnt", cycle_cnt_o, 37);
    chk("halt_beats", bc, 32);
`endif

    // Corner instance: HOLD_CYC=3, END_COUNT=1, REG_N=2.
    s_hold = 0; s_en = 0; s_beats = 0; found = 1'b0;
    @(posedge clk_i); #1 s_start = 1'b1;
    @(posedge clk_i); #1 s_start = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk_i);
      if (!s_cpu_rst) s_hold++;
      if (s_cpu_en) s_en++;
      if (s_valid && s_ready) begin
        chk("small_idx", s_idx, s_beats);
        chk("small_data", s_data, s_rf[s_beats]);
        s_beats++;
      end
      if (s_done) found = 1'b1;
    end
    chk("small_hold_cycles", s_hold, 3);
    chk("small_en_cycles", s_en, 1);
    chk("small_beats", s_beats, 2);
    chk("small_done", found, 1);
    chk("small_cnt", s_cnt, 1);

    repeat (2) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish by 400000");
    $fatal(1, "watchdog");
  end

endmodule
